instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 110 +++++++++++
 tb/tb_instr_encoder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Instruction encoder: packs register/immediate fields into 32-bit MIPS-style words
// and queues them, with a bound byte address, in a 2-entry output FIFO.
module instr_encoder (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [2:0]  kind_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [5:0]  funct_i,
  input  logic [15:0] imm_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] instr_o,
  output logic [9:0]  addr_o,
  output logic [7:0]  count_o,
  output logic        err_o
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [9:0]  addr;
  } word_t;

  state_t      state_q, state_d;
  word_t       head_q, tail_q, new_word;
  logic [9:0]  waddr_q;
  logic [7:0]  count_q;
  logic        err_q;
  logic [31:0] enc;
  logic        legal, accept, push, pop;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    enc   = '0;
    legal = 1'b1;
    case (kind_i)
      3'd0:    enc = {6'b000000, rs_i, rt_i, rd_i, 5'b00000, funct_i};
      3'd1:    enc = {6'b001101, rs_i, rt_i, imm_i};
      3'd2:    enc = {6'b001000, rs_i, rt_i, imm_i};
      3'd3:    enc = {6'b100011, rs_i, rt_i, imm_i};
      3'd4:    enc = {6'b101011, rs_i, rt_i, imm_i};
      3'd5:    enc = {6'b000100, rs_i, rt_i, imm_i};
      default: legal = 1'b0;
    endcase
  end

  assign new_word = '{instr: enc, addr: waddr_q};

  always_comb begin
    state_d = state_q;
    ready_o = (state_q != FULL);
    valid_o = (state_q != EMPTY);
    accept  = valid_i & ready_o;
    push    = accept & legal;
    pop     = valid_o & ready_i;
    case (state_q)
      EMPTY: if (push) state_d = ONE;
      ONE: begin
        if (push && !pop)      state_d = FULL;
        else if (pop && !push) state_d = EMPTY;
      end
      FULL:    if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  // NOTE: the word storage is deliberately not reset; the state register alone marks it valid.
  always_ff @(posedge clk_i) begin
    case (state_q)
      EMPTY: if (push) head_q <= new_word;
      ONE: begin
        if (push && pop) head_q <= new_word;
        else if (push)   tail_q <= new_word;
      end
      FULL:    if (pop) head_q <= tail_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      waddr_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (push) begin
        waddr_q <= waddr_q + 10'd4;
        if (count_q != 8'hFF) count_q <= count_q + 8'd1;
      end
      if (accept && !legal) err_q <= 1'b1;
    end
  end

  assign instr_o = head_q.instr;
  assign addr_o  = head_q.addr;
  assign count_o = count_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: table of hand-encoded vectors feeding a
// scoreboard queue, plus sequences for backpressure, illegal kinds, wrap and reset.
module tb_instr_encoder;

  logic        clk_i = 1'b0;
  logic        rst_i, valid_i, ready_o, valid_o, ready_i, err_o;
  logic [2:0]  kind_i;
  logic [4:0]  rs_i, rt_i, rd_i;
  logic [5:0]  funct_i;
  logic [15:0] imm_i;
  logic [31:0] instr_o;
  logic [9:0]  addr_o;
  logic [7:0]  count_o;

  instr_encoder dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .kind_i(kind_i), .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i), .funct_i(funct_i),
    .imm_i(imm_i), .valid_o(valid_o), .ready_i(ready_i), .instr_o(instr_o),
    .addr_o(addr_o), .count_o(count_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [2:0]  kind;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [9:0]  addr;
  } sb_t;

  vec_t        vecs[8];
  sb_t         sb[$];
  logic [31:0] cur_exp;
  logic [9:0]  m_addr;
  logic [7:0]  m_count;
  logic        m_err;
  bit          model_ok = 1'b0;
  bit          acc;
  int          total = 0;
  int          bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard model: occupancy is the queue size; updates mirror the next rising edge.
  always @(negedge clk_i) begin
    if (model_ok) begin
      check("ready_o", ready_o, sb.size() < 2);
      check("valid_o", valid_o, sb.size() != 0);
      check("count_o", count_o, m_count);
      check("err_o", err_o, m_err);
      if (sb.size() != 0) begin
        check("instr_o", instr_o, sb[0].instr);
        check("addr_o", addr_o, sb[0].addr);
      end
    end
    if (rst_i) begin
      sb.delete();
      m_addr   = '0;
      m_count  = '0;
      m_err    = 1'b0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      acc = valid_i && (sb.size() < 2);
      if (sb.size() != 0 && ready_i) void'(sb.pop_front());
      if (acc) begin
        if (kind_i < 3'd6) begin
          sb.push_back('{instr: cur_exp, addr: m_addr});
          m_addr = m_addr + 10'd4;
          if (m_count != 8'hFF) m_count = m_count + 8'd1;
        end else begin
          m_err = 1'b1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input vec_t v);
    valid_i = 1'b1;
    kind_i  = v.kind;
    rs_i    = v.rs;
    rt_i    = v.rt;
    rd_i    = v.rd;
    funct_i = v.funct;
    imm_i   = v.imm;
    cur_exp = v.exp;
    step();
  endtask

  task automatic drive_illegal(input logic [2:0] k);
    vec_t v;
    v = '{kind: k, rs: 5'd9, rt: 5'd9, rd: 5'd9, funct: 6'h11, imm: 16'hABCD, exp: 32'h0};
    drive(v);
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    valid_i = 1'b0;
    rst_i   = 1'b1;
    step();
    rst_i   = 1'b0;
  endtask

  initial begin
    vecs[0] = '{3'd0, 5'd1,  5'd2,  5'd3,  6'h20, 16'h0000, 32'h00221820};
    vecs[1] = '{3'd1, 5'd0,  5'd8,  5'd0,  6'h00, 16'h00FF, 32'h340800FF};
    vecs[2] = '{3'd3, 5'd29, 5'd4,  5'd0,  6'h00, 16'h0010, 32'h8FA40010};
    vecs[3] = '{3'd5, 5'd1,  5'd2,  5'd0,  6'h00, 16'hFFFF, 32'h1022FFFF};
    vecs[4] = '{3'd2, 5'd3,  5'd5,  5'd0,  6'h00, 16'h8000, 32'h20658000};
    vecs[5] = '{3'd4, 5'd31, 5'd31, 5'd0,  6'h00, 16'h1234, 32'hAFFF1234};
    vecs[6] = '{3'd0, 5'd31, 5'd0,  5'd31, 6'h3F, 16'hFFFF, 32'h03E0F83F};
    vecs[7] = '{3'd1, 5'd5,  5'd6,  5'd31, 6'h3F, 16'h0001, 32'h34A60001};

    valid_i = 1'b0; ready_i = 1'b1; kind_i = '0; rs_i = '0; rt_i = '0;
    rd_i = '0; funct_i = '0; imm_i = '0; cur_exp = '0; rst_i = 1'b1;
    step(); step();
    rst_i = 1'b0;

    // Every encoding back-to-back with ready_i=1 (push and pop together in ONE).
    for (int i = 0; i < 8; i++) drive(vecs[i]);
    idle(2);

    // ORI then LW from a fresh reset: addresses 0 and 4.
    do_reset();
    drive(vecs[1]);
    drive(vecs[2]);
    idle(2);

    // Backpressure: three requests, only two fit; head must hold while stalled.
    ready_i = 1'b0;
    drive(vecs[4]);
    drive(vecs[5]);
    check("ready_o_full", ready_o, 1'b0);
    drive(vecs[6]);
    idle(3);
    ready_i = 1'b1;
    idle(3);
    check("ready_o_drained", ready_o, 1'b1);

    // Illegal kind: sticky error, no word, then BEQ at the next unused address.
    drive_illegal(3'd7);
    check("err_o_set", err_o, 1'b1);
    check("valid_o_after_illegal", valid_o, 1'b0);
    drive(vecs[3]);
    idle(2);

    // Reset while FULL with err set, a coinciding transfer is discarded.
    ready_i = 1'b0;
    drive_illegal(3'd6);
    drive(vecs[0]);
    drive(vecs[1]);
    rst_i = 1'b1;
    drive(vecs[2]);
    rst_i = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    check("valid_o_after_rst", valid_o, 1'b0);
    check("ready_o_after_rst", ready_o, 1'b1);
    check("count_o_after_rst", count_o, 8'd0);
    check("err_o_after_rst", err_o, 1'b0);
    drive(vecs[7]);
    check("addr_o_after_rst", addr_o, 10'd0);
    idle(2);

    // Address wrap and count saturation over 257 legal pushes.
    do_reset();
    for (int i = 0; i < 257; i++) drive(vecs[i % 8]);
    check("addr_o_wrapped", addr_o, 10'd0);
    idle(2);
    check("count_o_saturated", count_o, 8'd255);
    check("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
